// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a picorv32-style native memory bus.
// Optional slave-ready watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              m_valid,
   input  logic [ADDR_WIDTH-1:0]   m_addr0,
   input  logic [DATA_WIDTH-1:0]   m_wdata0,
   input  logic [DATA_WIDTH/8-1:0] m_wstrb0,
   input  logic [ADDR_WIDTH-1:0]   m_addr1,
   input  logic [DATA_WIDTH-1:0]   m_wdata1,
   input  logic [DATA_WIDTH/8-1:0] m_wstrb1,
   output logic [1:0]              m_ready,
   output logic [DATA_WIDTH-1:0]   m_rdata,
   output logic                    s_valid,
   output logic [ADDR_WIDTH-1:0]   s_addr,
   output logic [DATA_WIDTH-1:0]   s_wdata,
   output logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              grant,
   output logic                    timeout
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, state_nxt;
   logic   gnt, gnt_nxt;
   logic   last, last_nxt;
   logic   busy, req_live, abort, done;

   assign busy     = (state == BUSY);
   assign req_live = busy && m_valid[gnt];

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WDOG_W-1:0] wdog;

   // Held at zero outside BUSY, so every grant starts a fresh count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdog <= '0;
      else if (!busy)
         wdog <= '0;
      else if (!s_ready)
         wdog <= wdog + WDOG_W'(1);
   end

   assign abort = req_live && !s_ready && (wdog == WDOG_W'(TIMEOUT - 1));
`else
   assign abort = 1'b0;
`endif

   assign done = req_live && (s_ready || abort);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (|m_valid) begin
               state_nxt = BUSY;
               // On a tie the master that did not finish last goes first.
               gnt_nxt   = (&m_valid) ? ~last : m_valid[1];
            end
         end
         BUSY: begin
            if (!m_valid[gnt]) begin
               state_nxt = IDLE;
            end else if (done) begin
               state_nxt = IDLE;
               last_nxt  = gnt;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // s_ready is deliberately ignored in IDLE: stale registered-valid slaves.
   always_comb begin
      m_ready = '0;
      m_rdata = s_rdata;
      s_valid = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      grant   = '0;
      timeout = 1'b0;
      if (busy) begin
         s_valid      = m_valid[gnt];
         s_addr       = gnt ? m_addr1  : m_addr0;
         s_wdata      = gnt ? m_wdata1 : m_wdata0;
         s_wstrb      = gnt ? m_wstrb1 : m_wstrb0;
         grant[gnt]   = 1'b1;
         m_ready[gnt] = done;
         if (abort) begin
            m_rdata = DATA_WIDTH'(32'hDEAD_BEEF);
            timeout = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level ownership model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;
   localparam int AW = 32, DW = 32, SW = 4, TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct packed { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } txn_t;
   typedef struct { logic [1:0] gr; logic [1:0] rdy; logic [31:0] rd; logic to; int run; } ev_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] m_valid = '0;
   logic [AW-1:0] m_addr0 = '0, m_addr1 = '0;
   logic [DW-1:0] m_wdata0 = '0, m_wdata1 = '0;
   logic [SW-1:0] m_wstrb0 = '0, m_wstrb1 = '0;
   logic [1:0] m_ready, grant;
   logic [DW-1:0] m_rdata, s_wdata, s_rdata;
   logic [AW-1:0] s_addr;
   logic [SW-1:0] s_wstrb;
   logic s_valid, s_ready, timeout;

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .m_valid(m_valid),
      .m_addr0(m_addr0), .m_wdata0(m_wdata0), .m_wstrb0(m_wstrb0),
      .m_addr1(m_addr1), .m_wdata1(m_wdata1), .m_wstrb1(m_wstrb1),
      .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .timeout(timeout));

   // Slave: ready after s_valid has been up slave_lat cycles, or forced.
   bit force_ready = 0, slave_hang = 0;
   int slave_lat = 1, slv_cnt = 0;
   assign s_ready = force_ready | (s_valid && !slave_hang && slv_cnt >= slave_lat);
   assign s_rdata = (s_addr == 32'h1004) ? 32'h1234_5678 : ~s_addr;
   always @(posedge clk) slv_cnt <= (s_valid && !s_ready) ? slv_cnt + 1 : 0;

   int n_checks = 0, n_err = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   txn_t q0[$], q1[$];
   ev_t log_q[$];
   logic [1:0] smp_v = '0, smp_mr = '0;
   logic smp_r = 0, smp_ab = 0;

   task automatic push(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m == 0) q0.push_back({a, d, s}); else q1.push_back({a, d, s});
   endtask

   // Masters: hold request until served, then present the next queued one.
   initial forever begin
      @(posedge clk); #1;
      if (smp_mr[0] && q0.size() != 0) q0.delete(0);
      if (smp_mr[1] && q1.size() != 0) q1.delete(0);
      m_valid[0] = (q0.size() != 0);
      m_valid[1] = (q1.size() != 0);
      if (q0.size() != 0) begin m_addr0 = q0[0].addr; m_wdata0 = q0[0].wdata; m_wstrb0 = q0[0].wstrb; end
      if (q1.size() != 0) begin m_addr1 = q1[0].addr; m_wdata1 = q1[0].wdata; m_wstrb1 = q1[0].wstrb; end
   end

   // Model: who owns the bus, who finished last, how long the owner has waited.
   int owner = -1, age = 0;
   bit last_w = 1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= -1; last_w <= 1; age <= 0;
      end else if (owner < 0) begin
         age <= 0;
         if (smp_v == 2'b11) owner <= last_w ? 0 : 1;
         else if (smp_v != 2'b00) owner <= smp_v[1] ? 1 : 0;
      end else if (!smp_v[owner]) begin
         owner <= -1;
      end else if (smp_r || smp_ab) begin
         last_w <= owner[0]; owner <= -1;
      end else begin
         age <= age + 1;
      end
   end

   initial begin : cmp
      logic [1:0] e_gr, e_mr;
      logic [31:0] e_addr, e_wd, e_rd;
      logic [3:0] e_ws;
      logic e_sv, e_ab, live;
      bit prev_done;
      int busy_run;
      prev_done = 0; busy_run = 0;
      forever begin
         @(negedge clk);
         e_gr = '0; e_mr = '0; e_addr = '0; e_wd = '0; e_ws = '0; e_sv = 0; e_ab = 0;
         if (owner >= 0) begin
            live   = m_valid[owner];
            e_gr   = (owner == 0) ? 2'b01 : 2'b10;
            e_sv   = live;
            e_addr = owner ? m_addr1 : m_addr0;
            e_wd   = owner ? m_wdata1 : m_wdata0;
            e_ws   = owner ? m_wstrb1 : m_wstrb0;
            e_ab   = TO_EN && live && !s_ready && (age == TO - 1);
            if (live && (s_ready || e_ab)) e_mr = e_gr;
         end
         e_rd = e_ab ? 32'hDEAD_BEEF : s_rdata;
         chk("grant", grant, e_gr);
         chk("m_ready", m_ready, e_mr);
         chk("s_valid", s_valid, e_sv);
         chk("s_addr", s_addr, e_addr);
         chk("s_wdata", s_wdata, e_wd);
         chk("s_wstrb", s_wstrb, e_ws);
         chk("m_rdata", m_rdata, e_rd);
         chk("timeout", timeout, e_ab);
         if (prev_done) chk("idle_gap", s_valid, 0);
         prev_done = |m_ready;
         busy_run = (grant != 0) ? busy_run + 1 : 0;
         if (m_ready != 0) log_q.push_back('{grant, m_ready, m_rdata, timeout, busy_run});
         smp_v = m_valid; smp_r = s_ready; smp_ab = e_ab; smp_mr = m_ready;
      end
   end

   task automatic wait_log(input int n, input string nm);
      int k = 0;
      while (log_q.size() < n && k < 200) begin @(negedge clk); k++; end
      chk({"wait_", nm}, log_q.size() >= n, 1);
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin : stim
      int k;
      repeat (2) @(negedge clk);
      chk("rst_grant", grant, 0); chk("rst_sv", s_valid, 0); chk("rst_mr", m_ready, 0);
      chk("rst_to", timeout, 0); chk("rst_addr", s_addr, 0); chk("rst_wstrb", s_wstrb, 0);
      @(posedge clk); #2; rst_n = 1;

      // T2: tie after reset alternates starting with master 0
      settle();
      push(0, 32'h100, 0, 0); push(0, 32'h104, 0, 0);
      push(1, 32'h200, 0, 0); push(1, 32'h204, 0, 0);
      wait_log(4, "t2");
      if (log_q.size() >= 4) begin
         chk("t2_g0", log_q[0].gr, 2'b01); chk("t2_g1", log_q[1].gr, 2'b10);
         chk("t2_g2", log_q[2].gr, 2'b01); chk("t2_g3", log_q[3].gr, 2'b10);
      end

      // T1: single read, one arbitration cycle then slave latency of 1
      settle(); log_q.delete();
      push(0, 32'h1004, 0, 0);
      @(negedge clk);
      @(negedge clk); chk("t1_arb_sv", s_valid, 0); chk("t1_arb_mv", m_valid, 2'b01);
      @(negedge clk); chk("t1_busy_sv", s_valid, 1); chk("t1_busy_gr", grant, 2'b01);
      chk("t1_busy_mr", m_ready, 0);
      @(negedge clk); chk("t1_mr", m_ready, 2'b01); chk("t1_rdata", m_rdata, 32'h1234_5678);
      @(negedge clk); chk("t1_idle_gr", grant, 0);

      // T3: write passthrough from master 1
      settle(); log_q.delete(); slave_lat = 2;
      push(1, 32'h2010, 32'hAABB_CCDD, 4'b0011);
      k = 0;
      do begin @(negedge clk); k++; end while (grant != 2'b10 && k < 20);
      chk("t3_gr", grant, 2'b10); chk("t3_addr", s_addr, 32'h2010);
      chk("t3_wdata", s_wdata, 32'hAABB_CCDD); chk("t3_wstrb", s_wstrb, 4'b0011);
      wait_log(1, "t3");
      if (log_q.size() >= 1) chk("t3_mr", log_q[0].rdy, 2'b10);
      slave_lat = 1;

      // T4: stale ready while idle must not complete anything
      settle(); force_ready = 1;
      repeat (3) begin @(negedge clk); chk("t4_idle_mr", m_ready, 0); end
      @(posedge clk); #2; push(0, 32'h3000, 0, 0);
      @(negedge clk);
      @(negedge clk); chk("t4_arb_mr", m_ready, 0); chk("t4_arb_mv", m_valid, 2'b01);
      @(negedge clk); chk("t4_busy_mr", m_ready, 2'b01);
      @(posedge clk); #2; force_ready = 0;

      // Master withdraws mid-BUSY: back to IDLE, no ready, last untouched
      settle(); slave_hang = 1;
      push(1, 32'h4000, 0, 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #2; q1.delete();
      @(posedge clk); #2;
      @(negedge clk); chk("drop_gr", grant, 2'b10); chk("drop_sv", s_valid, 0); chk("drop_mr", m_ready, 0);
      @(negedge clk); chk("drop_idle", grant, 0);
      @(posedge clk); #2; slave_hang = 0; log_q.delete();
      push(0, 32'h4100, 0, 0); push(1, 32'h4200, 0, 0);
      wait_log(2, "drop");
      if (log_q.size() >= 2) chk("drop_tie_first", log_q[0].gr, 2'b10);

      // T5: async reset while master 1 owns the bus
      settle(); slave_hang = 1;
      push(1, 32'h5000, 0, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!(grant == 2'b10 && s_valid) && k < 20);
      chk("t5_busy", grant, 2'b10);
      @(posedge clk); #2; rst_n = 0; #1;
      chk("t5_sv", s_valid, 0); chk("t5_gr", grant, 0); chk("t5_mr", m_ready, 0); chk("t5_addr", s_addr, 0);
      q0.delete(); q1.delete(); slave_hang = 0;
      repeat (2) @(posedge clk); #2; rst_n = 1; log_q.delete();
      push(0, 32'h5100, 0, 0); push(1, 32'h5200, 0, 0);
      wait_log(2, "t5");
      if (log_q.size() >= 2) begin
         chk("t5_first", log_q[0].gr, 2'b01); chk("t5_second", log_q[1].gr, 2'b10);
      end

      settle(); log_q.delete(); slave_hang = 1;
      push(0, 32'h6000, 0, 0);
`ifdef MEM_ARB_TIMEOUT_EN
      // T6: watchdog aborts on the 8th BUSY cycle
      wait_log(1, "t6");
      if (log_q.size() >= 1) begin
         chk("t6_to", log_q[0].to, 1); chk("t6_rdata", log_q[0].rd, 32'hDEAD_BEEF);
         chk("t6_mr", log_q[0].rdy, 2'b01); chk("t6_cycle", log_q[0].run, 8);
      end
      @(negedge clk); chk("t6_after_to", timeout, 0); chk("t6_after_gr", grant, 0);
      @(posedge clk); #2; slave_hang = 0;
`else
      // Without the watchdog a hung slave just keeps the grant
      repeat (14) @(negedge clk);
      chk("hang_gr", grant, 2'b01); chk("hang_mr", m_ready, 0); chk("hang_to", timeout, 0);
      @(posedge clk); #2; slave_hang = 0;
      wait_log(1, "hang");
      if (log_q.size() >= 1) chk("hang_done", log_q[0].rdy, 2'b01);
`endif
      settle();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1);
   end

endmodule
